// File: rtl/hpdcache_sync_fifo.sv
// Multi-entry synchronous FIFO with w/wok and r/rok handshakes, flush, occupancy and almost-full.
// Optional sticky protocol-error flag enabled by macro HPDCACHE_SYNC_FIFO_ERR_CHECK_EN.
module hpdcache_sync_fifo #(
    parameter int unsigned DEPTH        = 4,
    parameter bit          FEEDTHROUGH  = 1'b0,
    parameter int unsigned AFULL_THRESH = DEPTH - 1,
    parameter type         data_t       = logic,
    localparam int unsigned CNT_W       = $clog2(DEPTH + 1)
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             flush_i,
    input  logic             w_i,
    output logic             wok_o,
    input  data_t            wdata_i,
    input  logic             r_i,
    output logic             rok_o,
    output data_t            rdata_o,
    output logic [CNT_W-1:0] count_o,
    output logic             afull_o,
    output logic             err_o
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef logic [PTR_W-1:0] ptr_t;
    typedef logic [CNT_W-1:0] cnt_t;

    // Wrap explicitly at DEPTH-1 so non power-of-two depths cycle correctly.
    function automatic ptr_t ptr_incr(input ptr_t ptr);
        if (ptr == ptr_t'(DEPTH - 1)) begin
            return ptr_t'(0);
        end else begin
            return ptr + ptr_t'(1);
        end
    endfunction

    data_t storage_q [DEPTH];
    data_t storage_d [DEPTH];
    ptr_t  rptr_q, rptr_d;
    ptr_t  wptr_q, wptr_d;
    cnt_t  count_q, count_d;
    logic  afull_q, afull_d;

    logic empty_s, full_s;
    logic wok_s, rok_s;
    logic we_s, re_s;
    logic bypass_s;

    // Handshake decode and read-data selection
    always_comb begin
        empty_s  = (count_q == cnt_t'(0));
        full_s   = (count_q == cnt_t'(DEPTH));
        rok_s    = ~flush_i & (~empty_s | (FEEDTHROUGH & w_i));
        wok_s    = ~flush_i & (~full_s | (FEEDTHROUGH & r_i & ~empty_s));
        we_s     = w_i & wok_s;
        re_s     = r_i & rok_s;
        bypass_s = FEEDTHROUGH & empty_s & we_s & re_s;
        if (FEEDTHROUGH && empty_s) begin
            rdata_o = wdata_i;
        end else begin
            rdata_o = storage_q[rptr_q];
        end
    end

    // Next-state computation for pointers, occupancy and storage
    always_comb begin
        storage_d = storage_q;
        rptr_d    = rptr_q;
        wptr_d    = wptr_q;
        count_d   = count_q;
        if (flush_i) begin
            rptr_d  = ptr_t'(0);
            wptr_d  = ptr_t'(0);
            count_d = cnt_t'(0);
        end else if (bypass_s) begin
            // Payload went straight through to the reader; nothing is stored.
            count_d = count_q;
        end else begin
            if (we_s) begin
                storage_d[wptr_q] = wdata_i;
                wptr_d            = ptr_incr(wptr_q);
            end else begin
                wptr_d = wptr_q;
            end
            if (re_s) begin
                rptr_d = ptr_incr(rptr_q);
            end else begin
                rptr_d = rptr_q;
            end
            case ({we_s, re_s})
                2'b10:   count_d = count_q + cnt_t'(1);
                2'b01:   count_d = count_q - cnt_t'(1);
                default: count_d = count_q;
            endcase
        end
        afull_d = (count_d >= cnt_t'(AFULL_THRESH));
    end

    // Control state register with synchronous reset
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rptr_q  <= ptr_t'(0);
            wptr_q  <= ptr_t'(0);
            count_q <= cnt_t'(0);
            afull_q <= 1'b0;
        end else begin
            rptr_q  <= rptr_d;
            wptr_q  <= wptr_d;
            count_q <= count_d;
            afull_q <= afull_d;
        end
    end

    // Payload storage is never reset
    always_ff @(posedge clk_i) begin
        storage_q <= storage_d;
    end

`ifdef HPDCACHE_SYNC_FIFO_ERR_CHECK_EN
    logic err_q, err_d;

    // Sticky flag on write-to-full or read-from-empty outside of flush
    always_comb begin
        err_d = err_q | (~flush_i & ((w_i & ~wok_s) | (r_i & ~rok_s)));
    end

    // Error flag register, cleared only by reset
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_d;
        end
    end

    assign err_o = err_q;
`else
    assign err_o = 1'b0;
`endif

    assign wok_o   = wok_s;
    assign rok_o   = rok_s;
    assign count_o = count_q;
    assign afull_o = afull_q;

endmodule

// File: tb/tb_hpdcache_sync_fifo.sv
// Directed bench for hpdcache_sync_fifo: five configurations share one stimulus bus,
// each scenario task resets and checks the instance it targets.
module tb_hpdcache_sync_fifo;

    typedef logic [7:0] byte_t;

    logic  clk = 1'b0;
    logic  rst, flush, w, r;
    byte_t wdata;

    logic wok0, rok0, afull0, err0; byte_t rdata0; logic [2:0] cnt0;
    logic wok1, rok1, afull1, err1; byte_t rdata1; logic [2:0] cnt1;
    logic wok2, rok2, afull2, err2; byte_t rdata2; logic [1:0] cnt2;
    logic wok3, rok3, afull3, err3; byte_t rdata3; logic [1:0] cnt3;
    logic wok4, rok4, afull4, err4; byte_t rdata4; logic [0:0] cnt4;

    int ncmp = 0;
    int nerr = 0;

`ifdef HPDCACHE_SYNC_FIFO_ERR_CHECK_EN
    localparam logic ERR_EXP = 1'b1;
`else
    localparam logic ERR_EXP = 1'b0;
`endif

    always #5 clk = ~clk;

    hpdcache_sync_fifo #(.DEPTH(4), .FEEDTHROUGH(1'b0), .AFULL_THRESH(3), .data_t(byte_t)) u0 (
        .clk_i(clk), .rst_i(rst), .flush_i(flush), .w_i(w), .wok_o(wok0), .wdata_i(wdata),
        .r_i(r), .rok_o(rok0), .rdata_o(rdata0), .count_o(cnt0), .afull_o(afull0), .err_o(err0));
    hpdcache_sync_fifo #(.DEPTH(4), .FEEDTHROUGH(1'b1), .AFULL_THRESH(3), .data_t(byte_t)) u1 (
        .clk_i(clk), .rst_i(rst), .flush_i(flush), .w_i(w), .wok_o(wok1), .wdata_i(wdata),
        .r_i(r), .rok_o(rok1), .rdata_o(rdata1), .count_o(cnt1), .afull_o(afull1), .err_o(err1));
    hpdcache_sync_fifo #(.DEPTH(3), .FEEDTHROUGH(1'b0), .AFULL_THRESH(2), .data_t(byte_t)) u2 (
        .clk_i(clk), .rst_i(rst), .flush_i(flush), .w_i(w), .wok_o(wok2), .wdata_i(wdata),
        .r_i(r), .rok_o(rok2), .rdata_o(rdata2), .count_o(cnt2), .afull_o(afull2), .err_o(err2));
    hpdcache_sync_fifo #(.DEPTH(2), .FEEDTHROUGH(1'b1), .AFULL_THRESH(1), .data_t(byte_t)) u3 (
        .clk_i(clk), .rst_i(rst), .flush_i(flush), .w_i(w), .wok_o(wok3), .wdata_i(wdata),
        .r_i(r), .rok_o(rok3), .rdata_o(rdata3), .count_o(cnt3), .afull_o(afull3), .err_o(err3));
    hpdcache_sync_fifo #(.DEPTH(1), .FEEDTHROUGH(1'b0), .AFULL_THRESH(1), .data_t(byte_t)) u4 (
        .clk_i(clk), .rst_i(rst), .flush_i(flush), .w_i(w), .wok_o(wok4), .wdata_i(wdata),
        .r_i(r), .rok_o(rok4), .rdata_o(rdata4), .count_o(cnt4), .afull_o(afull4), .err_o(err4));

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1; flush = 1'b0; w = 1'b0; r = 1'b0; wdata = 8'h00;
        tick();
        rst = 1'b0;
        #1;
    endtask

    task automatic test_reset();
        do_reset();
        ncmp++; if (wok0 !== 1'b1) begin nerr++; $display("FAIL reset_wok: got %b want 1", wok0); end
        ncmp++; if (rok0 !== 1'b0) begin nerr++; $display("FAIL reset_rok: got %b want 0", rok0); end
        ncmp++; if (cnt0 !== 3'd0) begin nerr++; $display("FAIL reset_count: got %0d want 0", cnt0); end
        ncmp++; if (afull0 !== 1'b0) begin nerr++; $display("FAIL reset_afull: got %b want 0", afull0); end
        ncmp++; if (err0 !== 1'b0) begin nerr++; $display("FAIL reset_err: got %b want 0", err0); end
        w = 1'b1;
        #1;
        ncmp++; if (rok1 !== 1'b1) begin nerr++; $display("FAIL reset_ft_rok: got %b want 1", rok1); end
        w = 1'b0;
        #1;
    endtask

    task automatic test_fill_drain();
        do_reset();
        for (int i = 0; i < 4; i++) begin
            w = 1'b1; wdata = 8'hA0 + 8'(i);
            #1;
            ncmp++; if (wok0 !== 1'b1) begin nerr++; $display("FAIL fill_wok[%0d]: got %b want 1", i, wok0); end
            tick();
            ncmp++; if (cnt0 !== 3'(i + 1)) begin nerr++; $display("FAIL fill_count[%0d]: got %0d want %0d", i, cnt0, i + 1); end
            ncmp++; if (afull0 !== ((i + 1) >= 3)) begin nerr++; $display("FAIL fill_afull[%0d]: got %b want %b", i, afull0, (i + 1) >= 3); end
        end
        wdata = 8'hEE;
        #1;
        ncmp++; if (wok0 !== 1'b0) begin nerr++; $display("FAIL full_wok: got %b want 0", wok0); end
        w = 1'b0;
        for (int i = 0; i < 4; i++) begin
            r = 1'b1;
            #1;
            ncmp++; if (rok0 !== 1'b1) begin nerr++; $display("FAIL drain_rok[%0d]: got %b want 1", i, rok0); end
            ncmp++; if (rdata0 !== 8'hA0 + 8'(i)) begin nerr++; $display("FAIL drain_data[%0d]: got %h want %h", i, rdata0, 8'hA0 + 8'(i)); end
            tick();
            ncmp++; if (cnt0 !== 3'(3 - i)) begin nerr++; $display("FAIL drain_count[%0d]: got %0d want %0d", i, cnt0, 3 - i); end
        end
        r = 1'b0;
        #1;
        ncmp++; if (rok0 !== 1'b0) begin nerr++; $display("FAIL empty_rok: got %b want 0", rok0); end
    endtask

    task automatic test_feedthrough();
        do_reset();
        w = 1'b1; r = 1'b1; wdata = 8'h5A;
        #1;
        ncmp++; if (rok1 !== 1'b1) begin nerr++; $display("FAIL ft_rok: got %b want 1", rok1); end
        ncmp++; if (rdata1 !== 8'h5A) begin nerr++; $display("FAIL ft_data: got %h want 5a", rdata1); end
        ncmp++; if (wok1 !== 1'b1) begin nerr++; $display("FAIL ft_wok: got %b want 1", wok1); end
        tick();
        ncmp++; if (cnt1 !== 3'd0) begin nerr++; $display("FAIL ft_count: got %0d want 0", cnt1); end
        w = 1'b0; r = 1'b0;
        #1;
        ncmp++; if (rok1 !== 1'b0) begin nerr++; $display("FAIL ft_after_rok: got %b want 0", rok1); end
    endtask

    task automatic test_wrap();
        logic [9:0] wpat = 10'b1100110111;
        logic [9:0] rpat = 10'b0111011010;
        int nw = 0;
        int nr = 0;
        do_reset();
        w = 1'b1; wdata = 8'h30;
        tick();
        nw = 1;
        for (int k = 0; k < 10; k++) begin
            w = wpat[k]; r = rpat[k]; wdata = 8'h30 + 8'(nw);
            #1;
            if (wpat[k]) begin
                ncmp++; if (wok2 !== 1'b1) begin nerr++; $display("FAIL wrap_wok[%0d]: got %b want 1", k, wok2); end
            end
            if (rpat[k]) begin
                ncmp++; if (rdata2 !== 8'h30 + 8'(nr)) begin nerr++; $display("FAIL wrap_data[%0d]: got %h want %h", k, rdata2, 8'h30 + 8'(nr)); end
            end
            tick();
            if (wpat[k]) nw++;
            if (rpat[k]) nr++;
            ncmp++; if (cnt2 !== 2'(nw - nr)) begin nerr++; $display("FAIL wrap_count[%0d]: got %0d want %0d", k, cnt2, nw - nr); end
            ncmp++; if ((u2.wptr_q < 2'd3) !== 1'b1) begin nerr++; $display("FAIL wrap_wptr[%0d]: got %0d want <3", k, u2.wptr_q); end
            ncmp++; if ((u2.rptr_q < 2'd3) !== 1'b1) begin nerr++; $display("FAIL wrap_rptr[%0d]: got %0d want <3", k, u2.rptr_q); end
        end
        w = 1'b0;
        while (nr < nw) begin
            r = 1'b1;
            #1;
            ncmp++; if (rdata2 !== 8'h30 + 8'(nr)) begin nerr++; $display("FAIL wrap_tail[%0d]: got %h want %h", nr, rdata2, 8'h30 + 8'(nr)); end
            tick();
            nr++;
        end
        r = 1'b0;
        #1;
        ncmp++; if (cnt2 !== 2'd0) begin nerr++; $display("FAIL wrap_final_count: got %0d want 0", cnt2); end
    endtask

    task automatic test_full_ft();
        do_reset();
        w = 1'b1; wdata = 8'h11;
        tick();
        wdata = 8'h22;
        tick();
        ncmp++; if (cnt3 !== 2'd2) begin nerr++; $display("FAIL fullft_count: got %0d want 2", cnt3); end
        r = 1'b1; wdata = 8'h33;
        #1;
        ncmp++; if (wok3 !== 1'b1) begin nerr++; $display("FAIL fullft_wok: got %b want 1", wok3); end
        ncmp++; if (rdata3 !== 8'h11) begin nerr++; $display("FAIL fullft_x: got %h want 11", rdata3); end
        tick();
        ncmp++; if (cnt3 !== 2'd2) begin nerr++; $display("FAIL fullft_count_kept: got %0d want 2", cnt3); end
        w = 1'b0;
        #1;
        ncmp++; if (rdata3 !== 8'h22) begin nerr++; $display("FAIL fullft_y: got %h want 22", rdata3); end
        tick();
        ncmp++; if (rdata3 !== 8'h33) begin nerr++; $display("FAIL fullft_z: got %h want 33", rdata3); end
        tick();
        r = 1'b0;
        #1;
        ncmp++; if (cnt3 !== 2'd0) begin nerr++; $display("FAIL fullft_drained: got %0d want 0", cnt3); end
    endtask

    task automatic test_flush_reset();
        do_reset();
        w = 1'b1;
        for (int i = 0; i < 3; i++) begin
            wdata = 8'hC0 + 8'(i);
            tick();
        end
        ncmp++; if (cnt0 !== 3'd3) begin nerr++; $display("FAIL flush_pre_count: got %0d want 3", cnt0); end
        flush = 1'b1; r = 1'b1;
        #1;
        ncmp++; if (wok0 !== 1'b0) begin nerr++; $display("FAIL flush_wok: got %b want 0", wok0); end
        ncmp++; if (rok0 !== 1'b0) begin nerr++; $display("FAIL flush_rok: got %b want 0", rok0); end
        tick();
        flush = 1'b0; w = 1'b0; r = 1'b0;
        #1;
        ncmp++; if (cnt0 !== 3'd0) begin nerr++; $display("FAIL flush_count: got %0d want 0", cnt0); end
        ncmp++; if (afull0 !== 1'b0) begin nerr++; $display("FAIL flush_afull: got %b want 0", afull0); end
        ncmp++; if (rok0 !== 1'b0) begin nerr++; $display("FAIL flush_post_rok: got %b want 0", rok0); end
        w = 1'b1; wdata = 8'hD0;
        tick();
        wdata = 8'hD1;
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0; w = 1'b0;
        #1;
        ncmp++; if (cnt0 !== 3'd0) begin nerr++; $display("FAIL midrst_count: got %0d want 0", cnt0); end
        ncmp++; if (rok0 !== 1'b0) begin nerr++; $display("FAIL midrst_rok: got %b want 0", rok0); end
    endtask

    task automatic test_err();
        do_reset();
        ncmp++; if (err4 !== 1'b0) begin nerr++; $display("FAIL err_init: got %b want 0", err4); end
        w = 1'b1; wdata = 8'h77;
        tick();
        ncmp++; if (cnt4 !== 1'd1) begin nerr++; $display("FAIL err_count: got %0d want 1", cnt4); end
        ncmp++; if (afull4 !== 1'b1) begin nerr++; $display("FAIL err_afull: got %b want 1", afull4); end
        wdata = 8'h88;
        #1;
        ncmp++; if (wok4 !== 1'b0) begin nerr++; $display("FAIL err_wok: got %b want 0", wok4); end
        tick();
        w = 1'b0;
        #1;
        ncmp++; if (err4 !== ERR_EXP) begin nerr++; $display("FAIL err_set: got %b want %b", err4, ERR_EXP); end
        tick(); tick();
        ncmp++; if (err4 !== ERR_EXP) begin nerr++; $display("FAIL err_sticky: got %b want %b", err4, ERR_EXP); end
        r = 1'b1;
        #1;
        ncmp++; if (rdata4 !== 8'h77) begin nerr++; $display("FAIL err_data: got %h want 77", rdata4); end
        tick();
        r = 1'b0;
        #1;
        ncmp++; if (err4 !== ERR_EXP) begin nerr++; $display("FAIL err_after_read: got %b want %b", err4, ERR_EXP); end
        do_reset();
        ncmp++; if (err4 !== 1'b0) begin nerr++; $display("FAIL err_cleared: got %b want 0", err4); end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; flush = 1'b0; w = 1'b0; r = 1'b0; wdata = 8'h00;
        test_reset();
        test_fill_drain();
        test_feedthrough();
        test_wrap();
        test_full_ft();
        test_flush_reset();
        test_err();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
        $finish;
    end

endmodule
